// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency memory port between instruction fetch (IF) and
//   data load/store (MEM). A requester is granted combinationally in IDLE,
//   the memory is strobed for one cycle (ACCESS), and read data is captured
//   after MEM_LAT cycles (WAIT) and presented with a one-cycle valid pulse.
//
//   Build option: ARB_STARVE_GUARD_EN
//     defined   - data wins by default, but after STARVE_MAX consecutive data
//                 grants made while fetch was waiting, fetch is forced to win.
//     undefined - strict data-first priority.
//
//   Parameters
//     MEM_LAT     cycles from mem_en to mem_rdata valid (1..15)
//     STARVE_MAX  data grants over a waiting fetch before fetch wins (1..15)
//
//   Ports
//     clk, rst                    clock, synchronous active-high reset
//     if_req/if_addr              fetch request and word address
//     if_gnt/if_valid/if_rdata    fetch grant, completion pulse, instruction
//     d_req/d_we/d_addr/d_wdata   data request, store flag, address, store data
//     d_gnt/d_valid/d_rdata       data grant, completion pulse, load data
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//     stall_if/stall_mem          per-stage stall while an access is pending
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
  end

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  wait_cnt;
  logic        owner_d;      // 1: current access belongs to the data port
  logic        cap_we;
  logic [15:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        if_valid_q, d_valid_q;
  logic [15:0] if_rdata_q, d_rdata_q;
  logic        grant_if, grant_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Arbitration happens only in IDLE; a grant in a reset cycle is dropped.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state == IDLE && !rst) begin
`ifdef ARB_STARVE_GUARD_EN
      if (if_req && (!d_req || starved)) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
`else
      if (d_req) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_if || grant_d) state_nx = ACCESS;
      ACCESS:  state_nx = WAIT;
      WAIT:    if (wait_cnt == 4'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      owner_d    <= 1'b0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;

      if (grant_if || grant_d) begin
        owner_d   <= grant_d;
        cap_addr  <= grant_d ? d_addr : if_addr;
        cap_we    <= grant_d & d_we;
        cap_wdata <= grant_d ? d_wdata : '0;
      end

      if (state == ACCESS) begin
        wait_cnt <= LAT4;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // Last WAIT cycle: mem_rdata is valid now; the valid pulse follows in IDLE.
      if (state == WAIT && wait_cnt == 4'd1) begin
        if (owner_d) begin
          d_valid_q <= 1'b1;
          if (!cap_we) d_rdata_q <= mem_rdata;
        end else begin
          if_valid_q <= 1'b1;
          if_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) & cap_we;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign stall_if  = (if_req & ~grant_if) | (~owner_d & (state != IDLE));
  assign stall_mem = (d_req & ~grant_d) | (owner_d & (state != IDLE));

endmodule
